perceptron_infer: RTL and testbench

- Downstream consumer of the perceptron trainer: latches the trained weight set (w1, w2, w_bias) when the trainer reports completion.
- Classifies a stream of (x1, x2) samples using those weights.
- Arithmetic is sign-magnitude fixed point, Q_M integer / Q_N fraction bits, matching the trainer.
- One shared multiplier is stepped by an FSM; samples enter and results leave through valid/ready handshakes.

---
 rtl/perceptron_infer_if.sv | 36 +++
 rtl/perceptron_infer.sv | 153 +++++++++++++++
 tb/tb_perceptron_infer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/perceptron_infer_if.sv
// ============================================================================
// Module   : perceptron_infer_if
// Brief    : Weight-load, sample-in and result-out signals of perceptron_infer
// Revision : 1.0
// ============================================================================
`default_nettype none

interface perceptron_infer_if #(
    parameter int W = 32
);
    logic         weights_valid_i;
    logic [W-1:0] w1_i;
    logic [W-1:0] w2_i;
    logic [W-1:0] wb_i;
    logic         weights_loaded_o;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [W-1:0] x1_i;
    logic [W-1:0] x2_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [W-1:0] sum_o;
    logic         class_o;

    modport master (
        output weights_valid_i, w1_i, w2_i, wb_i, in_valid_i, x1_i, x2_i, out_ready_i,
        input  weights_loaded_o, in_ready_o, out_valid_o, sum_o, class_o
    );

    modport slave (
        input  weights_valid_i, w1_i, w2_i, wb_i, in_valid_i, x1_i, x2_i, out_ready_i,
        output weights_loaded_o, in_ready_o, out_valid_o, sum_o, class_o
    );
endinterface

`default_nettype wire

// File: rtl/perceptron_infer.sv
// ============================================================================
// Module   : perceptron_infer
// Brief    : Sign-magnitude perceptron classifier, one shared multiplier.
//            Define PERCEPTRON_SAT_EN to saturate on overflow instead of wrap.
// Revision : 1.0
// ============================================================================
`default_nettype none

module perceptron_infer #(
    parameter int             Q_M  = 15,
    parameter int             Q_N  = 16,
    parameter logic [Q_M+Q_N:0] BIAS = 32'h0001_0000
) (
    input  wire logic         clk_i,
    input  wire logic         reset_i,
    perceptron_infer_if.slave bus
);
    localparam int W = 1 + Q_M + Q_N;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL1 = 3'd1,
        S_MUL2 = 3'd2,
        S_MULB = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    state_t r_state, w_state_nxt;

    logic [W-1:0] r_w1, r_w2, r_wb;
    logic [W-1:0] r_w1s, r_w2s, r_wbs;
    logic [W-1:0] r_x1, r_x2;
    logic [W-1:0] r_acc, r_sum;
    logic         r_class, r_loaded;

    logic         w_in_ready, w_accept;
    logic [W-1:0] w_mul_a, w_mul_b;
    logic [2*(W-1)-1:0] w_prod;
    logic [W-2:0] w_mul_raw, w_mul_mag;
    logic         w_mul_ovf, w_mul_sgn;
    logic [W-1:0] w_add_a, w_add_b, w_add_sum, w_add_res;
    logic [W-2:0] w_add_raw, w_add_mag;
    logic         w_add_ovf, w_add_sgn;

    assign w_in_ready           = (r_state == S_IDLE) && r_loaded;
    assign w_accept             = bus.in_valid_i && w_in_ready;
    assign bus.in_ready_o       = w_in_ready;
    assign bus.weights_loaded_o = r_loaded;
    assign bus.out_valid_o      = (r_state == S_OUT);
    assign bus.sum_o            = r_sum;
    assign bus.class_o          = r_class;

    // Operand select for the single multiplier; the bias step is the default.
    always_comb begin
        w_mul_a = r_wbs;
        w_mul_b = BIAS;
        case (r_state)
            S_MUL1:  begin w_mul_a = r_w1s; w_mul_b = r_x1; end
            S_MUL2:  begin w_mul_a = r_w2s; w_mul_b = r_x2; end
            default: ;
        endcase
    end

    assign w_prod    = {{(W-1){1'b0}}, w_mul_a[W-2:0]} * {{(W-1){1'b0}}, w_mul_b[W-2:0]};
    assign w_mul_raw = w_prod[Q_N+W-2:Q_N];
    assign w_mul_ovf = |w_prod[2*(W-1)-1:Q_N+W-1];

    // First step adds the product to zero so every step shares one adder.
    assign w_add_a   = (r_state == S_MUL1) ? '0 : r_acc;
    assign w_add_b   = {w_mul_sgn, w_mul_mag};
    assign w_add_sum = {1'b0, w_add_a[W-2:0]} + {1'b0, w_add_b[W-2:0]};

    always_comb begin
        w_add_raw = w_add_sum[W-2:0];
        w_add_ovf = 1'b0;
        w_add_sgn = w_add_a[W-1];
        if (w_add_a[W-1] == w_add_b[W-1]) begin
            w_add_ovf = w_add_sum[W-1];
        end else if (w_add_a[W-2:0] >= w_add_b[W-2:0]) begin
            w_add_raw = w_add_a[W-2:0] - w_add_b[W-2:0];
        end else begin
            w_add_raw = w_add_b[W-2:0] - w_add_a[W-2:0];
            w_add_sgn = w_add_b[W-1];
        end
    end

`ifdef PERCEPTRON_SAT_EN
    assign w_mul_mag = w_mul_ovf ? '1 : w_mul_raw;
    assign w_add_mag = w_add_ovf ? '1 : w_add_raw;
`else
    logic w_unused_ovf;
    assign w_unused_ovf = w_mul_ovf | w_add_ovf;
    assign w_mul_mag    = w_mul_raw;
    assign w_add_mag    = w_add_raw;
`endif

    // A zero magnitude is always stored with a positive sign.
    assign w_mul_sgn = (w_mul_a[W-1] ^ w_mul_b[W-1]) & (|w_mul_mag);
    assign w_add_res = {w_add_sgn & (|w_add_mag), w_add_mag};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_MUL1;
            S_MUL1:  w_state_nxt = S_MUL2;
            S_MUL2:  w_state_nxt = S_MULB;
            S_MULB:  w_state_nxt = S_OUT;
            S_OUT:   if (bus.out_ready_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_w1 <= '0; r_w2 <= '0; r_wb <= '0;
            r_w1s <= '0; r_w2s <= '0; r_wbs <= '0;
            r_x1 <= '0; r_x2 <= '0;
            r_acc <= '0; r_sum <= '0;
            r_class <= 1'b0; r_loaded <= 1'b0;
        end else begin
            if (bus.weights_valid_i) begin
                r_w1     <= bus.w1_i;
                r_w2     <= bus.w2_i;
                r_wb     <= bus.wb_i;
                r_loaded <= 1'b1;
            end
            // A weight load coinciding with accept applies to this sample.
            if (w_accept) begin
                r_x1  <= bus.x1_i;
                r_x2  <= bus.x2_i;
                r_w1s <= bus.weights_valid_i ? bus.w1_i : r_w1;
                r_w2s <= bus.weights_valid_i ? bus.w2_i : r_w2;
                r_wbs <= bus.weights_valid_i ? bus.wb_i : r_wb;
            end
            case (r_state)
                S_MUL1, S_MUL2: r_acc <= w_add_res;
                S_MULB: begin
                    r_acc   <= w_add_res;
                    r_sum   <= w_add_res;
                    r_class <= ~w_add_res[W-1];
                end
                default: ;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_perceptron_infer.sv
// ============================================================================
// Module   : tb_perceptron_infer
// Brief    : Directed vectors with a queued expected-result monitor
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_perceptron_infer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

`ifdef PERCEPTRON_SAT_EN
    localparam logic [31:0] EXP_MUL_OVF = 32'h7FFF_FFFF;
    localparam logic [31:0] EXP_ADD_POS = 32'h7FFF_FFFF;
    localparam logic [31:0] EXP_ADD_NEG = 32'hFFFF_FFFF;
    localparam logic        EXP_NEG_CLS = 1'b0;
`else
    localparam logic [31:0] EXP_MUL_OVF = 32'h7FFE_0000;
    localparam logic [31:0] EXP_ADD_POS = 32'h0000_0000;
    localparam logic [31:0] EXP_ADD_NEG = 32'h0000_0000;
    localparam logic        EXP_NEG_CLS = 1'b1;
`endif

    perceptron_infer_if #(.W(32)) bus ();

    perceptron_infer dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    typedef struct packed {
        logic [31:0] sum;
        logic        cls;
    } exp_t;

    exp_t sb_q[$];
    int   tests  = 0;
    int   fails  = 0;
    int   pushes = 0;
    int   pops   = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_valid_o && bus.out_ready_i) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got sum %h, expected no output", bus.sum_o);
            end else begin
                e = sb_q.pop_front();
                pops++;
                check("sum", bus.sum_o, e.sum);
                check("class", {31'b0, bus.class_o}, {31'b0, e.cls});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_w(input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] wb);
        bus.w1_i = w1;
        bus.w2_i = w2;
        bus.wb_i = wb;
        bus.weights_valid_i = 1'b1;
        tick();
        bus.weights_valid_i = 1'b0;
    endtask

    task automatic send(input logic [31:0] x1, input logic [31:0] x2,
                        input logic [31:0] es, input logic ec, output int acc_cyc);
        int n = 0;
        bus.x1_i = x1;
        bus.x2_i = x2;
        bus.in_valid_i = 1'b1;
        while (!bus.in_ready_o && n < 50) begin
            tick();
            n++;
        end
        if (!bus.in_ready_o) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got in_ready 0, expected 1");
            bus.in_valid_i = 1'b0;
            acc_cyc = -1;
            return;
        end
        sb_q.push_back({es, ec});
        pushes++;
        acc_cyc = cyc;
        tick();
        bus.in_valid_i = 1'b0;
        tick();
        tick();
        check("latency_before", {31'b0, bus.out_valid_o}, 32'd0);
        tick();
        check("latency_valid", {31'b0, bus.out_valid_o}, 32'd1);
    endtask

    initial begin
        int c1, c2, n;
        logic bad;
        bus.weights_valid_i = 1'b0;
        bus.w1_i = '0; bus.w2_i = '0; bus.wb_i = '0;
        bus.in_valid_i = 1'b0;
        bus.x1_i = '0; bus.x2_i = '0;
        bus.out_ready_i = 1'b1;

        tick(); tick();
        check("rst_loaded", {31'b0, bus.weights_loaded_o}, 32'd0);
        check("rst_ready", {31'b0, bus.in_ready_o}, 32'd0);
        check("rst_valid", {31'b0, bus.out_valid_o}, 32'd0);
        check("rst_sum", bus.sum_o, 32'd0);
        check("rst_class", {31'b0, bus.class_o}, 32'd0);
        rst = 1'b0;
        tick();

        // No weights yet: samples must be refused.
        bus.x1_i = 32'h0001_0000;
        bus.in_valid_i = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.in_ready_o || bus.out_valid_o) bad = 1'b1;
            tick();
        end
        bus.in_valid_i = 1'b0;
        check("no_weights_idle", {31'b0, bad}, 32'd0);

        load_w(32'h0000_2000, 32'h8000_8000, 32'h0000_4000);
        check("loaded", {31'b0, bus.weights_loaded_o}, 32'd1);
        send(32'h0001_0000, 32'h0001_0000, 32'h8000_2000, 1'b0, c1);
        send(32'h0001_0000, 32'h0000_0000, 32'h0000_6000, 1'b1, c2);
        check("throughput", c2 - c1, 32'd5);

        load_w(32'h0000_8000, 32'h8000_8000, 32'h0000_0000);
        send(32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, c1);

        load_w(32'h8001_0000, 32'h0001_0000, 32'h0000_8000);
        send(32'h8002_0000, 32'h8003_0000, 32'h8000_8000, 1'b0, c1);

        load_w(32'h7FFF_0000, 32'h0000_0000, 32'h0000_0000);
        send(32'h0002_0000, 32'h0000_0000, EXP_MUL_OVF, 1'b1, c1);

        load_w(32'h4000_0000, 32'h4000_0000, 32'h0000_0000);
        send(32'h0001_0000, 32'h0001_0000, EXP_ADD_POS, 1'b1, c1);

        load_w(32'hC000_0000, 32'hC000_0000, 32'h0000_0000);
        send(32'h0001_0000, 32'h0001_0000, EXP_ADD_NEG, EXP_NEG_CLS, c1);

        // Consumer stalls while new samples are offered.
        load_w(32'h0000_2000, 32'h8000_8000, 32'h0000_4000);
        bus.out_ready_i = 1'b0;
        send(32'h0001_0000, 32'h0001_0000, 32'h8000_2000, 1'b0, c1);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid_i = 1'b1;
            bus.x1_i = 32'h0005_0000;
            check("hold_sum", bus.sum_o, 32'h8000_2000);
            check("hold_valid", {31'b0, bus.out_valid_o}, 32'd1);
            check("hold_ready", {31'b0, bus.in_ready_o}, 32'd0);
            tick();
        end
        bus.in_valid_i = 1'b0;
        bus.out_ready_i = 1'b1;
        tick();
        check("release_valid", {31'b0, bus.out_valid_o}, 32'd0);
        check("release_ready", {31'b0, bus.in_ready_o}, 32'd1);

        // Reset while the second multiply step is in progress.
        bus.x1_i = 32'h0001_0000;
        bus.x2_i = 32'h0001_0000;
        bus.in_valid_i = 1'b1;
        tick();
        bus.in_valid_i = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("midrst_valid", {31'b0, bus.out_valid_o}, 32'd0);
        check("midrst_loaded", {31'b0, bus.weights_loaded_o}, 32'd0);
        check("midrst_ready", {31'b0, bus.in_ready_o}, 32'd0);
        check("midrst_sum", bus.sum_o, 32'd0);
        tick();
        rst = 1'b0;
        bus.in_valid_i = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.in_ready_o || bus.out_valid_o) bad = 1'b1;
        end
        bus.in_valid_i = 1'b0;
        check("post_rst_no_accept", {31'b0, bad}, 32'd0);
        load_w(32'h0000_2000, 32'h8000_8000, 32'h0000_4000);
        send(32'h0001_0000, 32'h0000_0000, 32'h0000_6000, 1'b1, c1);

        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        tick();
        check("all_results_seen", pops, pushes);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

`default_nettype wire
